// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped instruction cache controller.
// One 32-bit word per line, 2^INDEX_WIDTH lines. Hits answer one cycle after
// the request is accepted; misses raise a refill request to the memory
// controller and forward the returned word to the fetcher.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   rdy                         global ready; low freezes all state
//   ena_from_if, pc_from_if     fetch request and word-aligned address
//   drop_flag_from_if           fetcher abandons its outstanding request
//   commit_jump_flag_from_rob   misprediction flush
//   ok_flag_to_if, inst_to_if   one-cycle response pulse and instruction
//   ena_to_mc, pc_to_mc         refill request and address
//   drop_flag_to_mc             one-cycle cancel of the in-flight refill
//   ok_flag_from_mc, inst_from_mc  refill data valid and data
//
// state | meaning
// IDLE  | waiting for a fetch; lookups happen here
// MISS  | refill outstanding at the memory controller
// DROP  | refill cancelled; cancel pulse on drop_flag_to_mc this cycle
module icache_ctrl #(
   parameter int INDEX_WIDTH = 6,
   parameter int TAG_WIDTH   = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        ena_from_if,
   input  logic [31:0] pc_from_if,
   input  logic        drop_flag_from_if,
   input  logic        commit_jump_flag_from_rob,
   output logic        ok_flag_to_if,
   output logic [31:0] inst_to_if,
   output logic        ena_to_mc,
   output logic [31:0] pc_to_mc,
   output logic        drop_flag_to_mc,
   input  logic        ok_flag_from_mc,
   input  logic [31:0] inst_from_mc
);

   localparam int LINES   = 1 << INDEX_WIDTH;
   localparam int TAG_LSB = INDEX_WIDTH + 2;
   localparam int TAG_MSB = TAG_WIDTH + INDEX_WIDTH + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MISS = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [LINES-1:0]     valid_q;
   logic [TAG_WIDTH-1:0] tag_q  [LINES];
   logic [31:0]          data_q [LINES];

   logic        ok_q, ok_d;
   logic        hit_q, hit_d;
   logic [31:0] inst_q, inst_d;
   logic        ena_q, ena_d;
   logic        drop_q, drop_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        fill;

   logic [INDEX_WIDTH-1:0] idx_in, fill_idx;
   logic [TAG_WIDTH-1:0]   tag_in, fill_tag;
   logic                   lookup_hit;
   logic                   abort;
   logic                   accept;

   assign idx_in     = pc_from_if[INDEX_WIDTH+1:2];
   assign tag_in     = pc_from_if[TAG_MSB:TAG_LSB];
   assign fill_idx   = req_pc_q[INDEX_WIDTH+1:2];
   assign fill_tag   = req_pc_q[TAG_MSB:TAG_LSB];
   assign lookup_hit = valid_q[idx_in] && (tag_q[idx_in] == tag_in);
   assign abort      = drop_flag_from_if || commit_jump_flag_from_rob;

   // While a response is on the bus the fetcher still holds its old request;
   // refusing to accept that cycle keeps the response a single-cycle pulse.
   assign accept = (state_q == S_IDLE) && ena_from_if && !abort && !ok_q;

   // Offset and above-tag address bits do not select anything.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{pc_from_if[1:0], pc_from_if[31:TAG_MSB+1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else if (rdy) begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept && !lookup_hit) state_d = S_MISS;
         end
         S_MISS: begin
            if (ok_flag_from_mc) state_d = S_IDLE;
            else if (abort)      state_d = S_DROP;
         end
         S_DROP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ok_d     = 1'b0;
      hit_d    = 1'b0;
      inst_d   = inst_q;
      ena_d    = ena_q;
      drop_d   = 1'b0;
      req_pc_d = req_pc_q;
      fill     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               req_pc_d = pc_from_if;
               if (lookup_hit) begin
                  ok_d   = 1'b1;
                  hit_d  = 1'b1;
                  inst_d = data_q[idx_in];
               end else begin
                  ena_d = 1'b1;
               end
            end
         end
         S_MISS: begin
            if (ok_flag_from_mc) begin
               // The word is correct for req_pc even if the request was
               // abandoned, so the line is kept either way.
               fill  = 1'b1;
               ena_d = 1'b0;
               if (!abort) begin
                  ok_d   = 1'b1;
                  inst_d = inst_from_mc;
               end
            end else if (abort) begin
               ena_d  = 1'b0;
               drop_d = 1'b1;
            end
         end
         default: ;
      endcase
      // A hit answered in the same cycle as a flush belongs to the wrong path.
      ok_flag_to_if = ok_q && !(hit_q && commit_jump_flag_from_rob && rdy);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= '0;
         ok_q     <= 1'b0;
         hit_q    <= 1'b0;
         inst_q   <= '0;
         ena_q    <= 1'b0;
         drop_q   <= 1'b0;
         req_pc_q <= '0;
      end else if (rdy) begin
         ok_q     <= ok_d;
         hit_q    <= hit_d;
         inst_q   <= inst_d;
         ena_q    <= ena_d;
         drop_q   <= drop_d;
         req_pc_q <= req_pc_d;
         if (fill) valid_q[fill_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && rdy && fill) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= inst_from_mc;
      end
   end

   assign inst_to_if      = inst_q;
   assign ena_to_mc       = ena_q;
   assign pc_to_mc        = req_pc_q;
   assign drop_flag_to_mc = drop_q;

endmodule

// File: tb/tb_icache_ctrl.sv
module tb_icache_ctrl;

   logic        clk = 1'b0;
   logic        rst, rdy, ena_from_if, drop_flag_from_if, commit_jump_flag_from_rob;
   logic [31:0] pc_from_if, inst_from_mc;
   logic        ok_flag_from_mc;
   logic        ok_flag_to_if, ena_to_mc, drop_flag_to_mc;
   logic [31:0] inst_to_if, pc_to_mc;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   icache_ctrl #(.INDEX_WIDTH(6), .TAG_WIDTH(10)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .ena_from_if(ena_from_if), .pc_from_if(pc_from_if),
      .drop_flag_from_if(drop_flag_from_if),
      .commit_jump_flag_from_rob(commit_jump_flag_from_rob),
      .ok_flag_to_if(ok_flag_to_if), .inst_to_if(inst_to_if),
      .ena_to_mc(ena_to_mc), .pc_to_mc(pc_to_mc),
      .drop_flag_to_mc(drop_flag_to_mc),
      .ok_flag_from_mc(ok_flag_from_mc), .inst_from_mc(inst_from_mc)
   );

   typedef struct {
      logic [31:0] pc;
      bit          exp_hit;
      int          lat;
      string       name;
   } vec_t;

   vec_t vecs [12];

   function automatic logic [31:0] mem_word(input logic [31:0] pc);
      return (pc == 32'h0) ? 32'h0000_0513 : (pc ^ 32'h1357_9BDF);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Starts and ends on a negedge. The bench plays the memory controller,
   // answering lat cycles after the request appears.
   task automatic do_fetch(input logic [31:0] pc, input bit exp_hit, input int lat,
                           input string name);
      bit got = 0;
      bit saw = 0;
      logic [31:0] exp_v;
      exp_q.push_back(mem_word(pc));
      ena_from_if = 1'b1;
      pc_from_if  = pc;
      for (int i = 1; i <= 40 && !got; i++) begin
         @(negedge clk);
         ok_flag_from_mc = 1'b0;
         if (ok_flag_to_if) begin
            got = 1;
            ena_from_if = 1'b0;
            chk({name, "_latency"}, i, exp_hit ? 1 : lat + 1);
            chk({name, "_miss_path"}, {31'b0, saw}, {31'b0, !exp_hit});
            exp_v = exp_q.pop_front();
            chk({name, "_inst"}, inst_to_if, exp_v);
            chk({name, "_ena_mc_low"}, {31'b0, ena_to_mc}, 32'h0);
         end else if (ena_to_mc) begin
            if (!saw) chk({name, "_pc_to_mc"}, pc_to_mc, pc);
            saw = 1;
            if (i == lat) begin
               ok_flag_from_mc = 1'b1;
               inst_from_mc    = mem_word(pc);
            end
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no response expected one", name);
         ena_from_if = 1'b0;
         ok_flag_from_mc = 1'b0;
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      @(negedge clk);
      chk({name, "_single_pulse"}, {31'b0, ok_flag_to_if}, 32'h0);
   endtask

   initial begin
      logic [31:0] exp_v;
      vecs[0]  = '{32'h0000_0000, 1'b0, 3, "cold_miss"};
      vecs[1]  = '{32'h0000_0000, 1'b1, 0, "rehit_0"};
      vecs[2]  = '{32'h0000_0100, 1'b0, 2, "fill_100"};
      vecs[3]  = '{32'h0000_0000, 1'b0, 1, "conflict_0"};
      vecs[4]  = '{32'h0000_0100, 1'b0, 4, "conflict_100"};
      vecs[5]  = '{32'h0000_0104, 1'b0, 1, "fill_104"};
      vecs[6]  = '{32'h0000_0104, 1'b1, 0, "hit_104"};
      vecs[7]  = '{32'h0000_0100, 1'b1, 0, "hit_100"};
      vecs[8]  = '{32'h0003_FFFC, 1'b0, 2, "fill_top"};
      vecs[9]  = '{32'h0003_FFFC, 1'b1, 0, "hit_top"};
      vecs[10] = '{32'h0000_00FC, 1'b0, 2, "conflict_fc"};
      vecs[11] = '{32'h0003_FFFC, 1'b0, 1, "refill_top"};

      rst = 1'b1; rdy = 1'b1; ena_from_if = 1'b0; pc_from_if = '0;
      drop_flag_from_if = 1'b0; commit_jump_flag_from_rob = 1'b0;
      ok_flag_from_mc = 1'b0; inst_from_mc = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_ok", {31'b0, ok_flag_to_if}, 32'h0);
      chk("rst_inst", inst_to_if, 32'h0);
      chk("rst_ena_mc", {31'b0, ena_to_mc}, 32'h0);
      chk("rst_pc_mc", pc_to_mc, 32'h0);
      chk("rst_drop_mc", {31'b0, drop_flag_to_mc}, 32'h0);

      for (int v = 0; v < 12; v++)
         do_fetch(vecs[v].pc, vecs[v].exp_hit, vecs[v].lat, vecs[v].name);

      // Flush during MISS before the refill returns
      ena_from_if = 1'b1; pc_from_if = 32'h0000_0200;
      @(negedge clk);
      chk("jmiss_ena", {31'b0, ena_to_mc}, 32'h1);
      @(negedge clk);
      commit_jump_flag_from_rob = 1'b1; ena_from_if = 1'b0;
      @(negedge clk);
      commit_jump_flag_from_rob = 1'b0;
      chk("jmiss_drop_pulse", {31'b0, drop_flag_to_mc}, 32'h1);
      chk("jmiss_ena_low", {31'b0, ena_to_mc}, 32'h0);
      chk("jmiss_no_ok", {31'b0, ok_flag_to_if}, 32'h0);
      @(negedge clk);
      chk("jmiss_drop_once", {31'b0, drop_flag_to_mc}, 32'h0);
      chk("jmiss_no_ok2", {31'b0, ok_flag_to_if}, 32'h0);
      do_fetch(32'h0000_0200, 1'b0, 2, "after_drop");

      // Flush coincident with the refill data
      ena_from_if = 1'b1; pc_from_if = 32'h0000_0300;
      @(negedge clk);
      chk("jcoin_ena", {31'b0, ena_to_mc}, 32'h1);
      ok_flag_from_mc = 1'b1; inst_from_mc = mem_word(32'h0000_0300);
      commit_jump_flag_from_rob = 1'b1; ena_from_if = 1'b0;
      @(negedge clk);
      ok_flag_from_mc = 1'b0; commit_jump_flag_from_rob = 1'b0;
      chk("jcoin_no_ok", {31'b0, ok_flag_to_if}, 32'h0);
      chk("jcoin_no_drop", {31'b0, drop_flag_to_mc}, 32'h0);
      chk("jcoin_ena_low", {31'b0, ena_to_mc}, 32'h0);
      @(negedge clk);
      chk("jcoin_no_ok2", {31'b0, ok_flag_to_if}, 32'h0);
      do_fetch(32'h0000_0300, 1'b1, 0, "after_coin");

      // Hit response suppressed by a flush in its response cycle
      ena_from_if = 1'b1; pc_from_if = 32'h0000_0300;
      @(negedge clk);
      commit_jump_flag_from_rob = 1'b1; ena_from_if = 1'b0;
      #1;
      chk("jhit_suppressed", {31'b0, ok_flag_to_if}, 32'h0);
      @(negedge clk);
      commit_jump_flag_from_rob = 1'b0;
      chk("jhit_still_quiet", {31'b0, ok_flag_to_if}, 32'h0);

      // rdy low for 4 cycles mid-MISS shifts completion by 4
      exp_q.push_back(mem_word(32'h0000_0400));
      ena_from_if = 1'b1; pc_from_if = 32'h0000_0400;
      @(negedge clk);
      chk("frz_ena", {31'b0, ena_to_mc}, 32'h1);
      rdy = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("frz_ena_held", {31'b0, ena_to_mc}, 32'h1);
         chk("frz_pc_held", pc_to_mc, 32'h0000_0400);
         chk("frz_no_ok", {31'b0, ok_flag_to_if}, 32'h0);
         chk("frz_no_drop", {31'b0, drop_flag_to_mc}, 32'h0);
      end
      rdy = 1'b1;
      @(negedge clk);
      chk("frz_ena_n6", {31'b0, ena_to_mc}, 32'h1);
      @(negedge clk);
      chk("frz_ena_n7", {31'b0, ena_to_mc}, 32'h1);
      chk("frz_no_ok_n7", {31'b0, ok_flag_to_if}, 32'h0);
      ok_flag_from_mc = 1'b1; inst_from_mc = mem_word(32'h0000_0400);
      @(negedge clk);
      ok_flag_from_mc = 1'b0; ena_from_if = 1'b0;
      chk("frz_ok", {31'b0, ok_flag_to_if}, 32'h1);
      exp_v = exp_q.pop_front();
      chk("frz_inst", inst_to_if, exp_v);
      chk("frz_ena_done", {31'b0, ena_to_mc}, 32'h0);
      @(negedge clk);
      chk("frz_single_pulse", {31'b0, ok_flag_to_if}, 32'h0);

      // Reset mid-MISS aborts quietly and invalidates the cache
      ena_from_if = 1'b1; pc_from_if = 32'h0000_0500;
      @(negedge clk);
      chk("rmiss_ena", {31'b0, ena_to_mc}, 32'h1);
      rst = 1'b1; ena_from_if = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("rmiss_ok", {31'b0, ok_flag_to_if}, 32'h0);
      chk("rmiss_inst", inst_to_if, 32'h0);
      chk("rmiss_ena_mc", {31'b0, ena_to_mc}, 32'h0);
      chk("rmiss_pc_mc", pc_to_mc, 32'h0);
      chk("rmiss_drop", {31'b0, drop_flag_to_mc}, 32'h0);
      ok_flag_from_mc = 1'b1; inst_from_mc = 32'hDEAD_BEEF;
      @(negedge clk);
      ok_flag_from_mc = 1'b0;
      chk("stray_ok_ignored", {31'b0, ok_flag_to_if}, 32'h0);
      chk("stray_no_ena", {31'b0, ena_to_mc}, 32'h0);
      do_fetch(32'h0000_0104, 1'b0, 2, "post_rst_104");

      chk("scoreboard_empty", exp_q.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
